// File: rtl/ddd_pkg.sv
// Shared types and constants for the triangle sequencer: vertex layout,
// triangle field offsets and the sequencer state encoding.
package ddd_pkg;

   localparam int TRI_W     = 160;
   localparam int VTX_W     = 48;
   localparam int COLOR_LSB = 144;
   localparam int V0_LSB    = 96;
   localparam int V1_LSB    = 48;
   localparam int V2_LSB    = 0;

   typedef struct packed {
      logic signed [15:0] x;
      logic signed [15:0] y;
      logic signed [15:0] z;
   } vertex_t;

   typedef logic [2:0] seq_state_t;

   localparam seq_state_t ST_IDLE  = 3'd0;
   localparam seq_state_t ST_CHECK = 3'd1;
   localparam seq_state_t ST_EMIT0 = 3'd2;
   localparam seq_state_t ST_EMIT1 = 3'd3;
   localparam seq_state_t ST_EMIT2 = 3'd4;
   localparam seq_state_t ST_DONE  = 3'd5;

   // 17-bit difference clamped symmetrically so -32768 can never appear
   function automatic logic signed [15:0] sat_sub(input logic signed [15:0] a,
                                                  input logic signed [15:0] b,
                                                  input int                 sat);
      logic signed [16:0] d;
      logic signed [16:0] lim;
      logic signed [16:0] nlim;
      d    = {a[15], a} - {b[15], b};
      lim  = 17'(sat);
      nlim = -lim;
      if (d > lim)
         return lim[15:0];
      else if (d < nlim)
         return nlim[15:0];
      else
         return d[15:0];
   endfunction

endpackage

// File: rtl/ddd_triangle_sequencer_if.sv
// Upstream triangle handshake: one whole world-space triangle per transfer.
interface ddd_triangle_sequencer_if;
   import ddd_pkg::*;

   logic [TRI_W-1:0] tri_in;
   logic             tri_last;
   logic             tri_valid;
   logic             tri_ready;

   modport master (output tri_in, output tri_last, output tri_valid, input  tri_ready);
   modport slave  (input  tri_in, input  tri_last, input  tri_valid, output tri_ready);

endinterface

// File: rtl/ddd_vertex_offset.sv
// One vertex translated into camera space with saturation, plus the
// near-plane test on the resulting z.
module ddd_vertex_offset
   import ddd_pkg::*;
#(
   parameter int Z_NEAR  = 16,
   parameter int SAT_MAX = 32767
) (
   input  vertex_t v,
   input  vertex_t cam,
   output vertex_t rel,
   output logic    below_near
);

   localparam logic signed [15:0] ZN = 16'(Z_NEAR);

   always_comb begin
      rel.x      = sat_sub(v.x, cam.x, SAT_MAX);
      rel.y      = sat_sub(v.y, cam.y, SAT_MAX);
      rel.z      = sat_sub(v.z, cam.z, SAT_MAX);
      below_near = (rel.z < ZN);
   end

endmodule

// File: rtl/ddd_triangle_sequencer.sv
// Triangle feeder for the projection stage: camera offset, near-plane cull,
// 3-beat vertex serialisation. DDD_CULL_STATS_EN adds cull/emit counters.
//
// state | meaning
// IDLE  | ready for a triangle; frame_start latches the camera here
// CHECK | offset vertices, decide cull
// EMIT0 | v0 beat with new-triangle marker
// EMIT1 | v1 beat
// EMIT2 | v2 beat; next triangle may be accepted here unless last
// DONE  | one-cycle end-of-frame pulse
module ddd_triangle_sequencer
   import ddd_pkg::*;
#(
   parameter int Z_NEAR  = 16,
   parameter int SAT_MAX = 32767
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     frame_start,
   input  logic signed [15:0]       cam_x,
   input  logic signed [15:0]       cam_y,
   input  logic signed [15:0]       cam_z,
   ddd_triangle_sequencer_if.slave  tri_if,
   output logic [VTX_W-1:0]         vertex,
   output logic [15:0]              color,
   output logic                     new_triangle_out,
   output logic                     done_out
`ifdef DDD_CULL_STATS_EN
   ,
   output logic [15:0]              culled_count,
   output logic [15:0]              emitted_count
`endif
);

   seq_state_t       state_q, state_d;
   logic [TRI_W-1:0] tri_q, tri_d;
   logic             last_q, last_d;
   vertex_t          cam_q, cam_d;
   vertex_t          rel1_q, rel1_d;
   vertex_t          rel2_q, rel2_d;
   logic [VTX_W-1:0] vertex_q, vertex_d;
   logic [15:0]      color_q, color_d;
   logic             new_tri_q, new_tri_d;
   logic             done_q, done_d;
   logic             ready_q, ready_d;

   logic             accept;
   logic             cam_load;
   logic             cull;
   vertex_t          v_in [3];
   vertex_t          rel  [3];
   logic             below[3];

   assign v_in[0] = vertex_t'(tri_q[V0_LSB +: VTX_W]);
   assign v_in[1] = vertex_t'(tri_q[V1_LSB +: VTX_W]);
   assign v_in[2] = vertex_t'(tri_q[V2_LSB +: VTX_W]);

   for (genvar i = 0; i < 3; i++) begin : g_off
      ddd_vertex_offset #(.Z_NEAR(Z_NEAR), .SAT_MAX(SAT_MAX)) u_off (
         .v          (v_in[i]),
         .cam        (cam_q),
         .rel        (rel[i]),
         .below_near (below[i])
      );
   end

   assign cull     = below[0] | below[1] | below[2];
   assign accept   = tri_if.tri_valid & ready_q;
   assign cam_load = (state_q == ST_IDLE) & ~accept & frame_start;

   always_comb begin
      state_d = state_q;
      tri_d   = tri_q;
      last_d  = last_q;
      cam_d   = cam_q;
      rel1_d  = rel1_q;
      rel2_d  = rel2_q;
      color_d = color_q;
      if (cam_load)
         cam_d = {cam_x, cam_y, cam_z};
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               tri_d   = tri_if.tri_in;
               last_d  = tri_if.tri_last;
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            rel1_d = rel[1];
            rel2_d = rel[2];
            if (cull) begin
               state_d = last_q ? ST_DONE : ST_IDLE;
            end else begin
               color_d = tri_q[COLOR_LSB +: 16];
               state_d = ST_EMIT0;
            end
         end
         ST_EMIT0: state_d = ST_EMIT1;
         ST_EMIT1: state_d = ST_EMIT2;
         ST_EMIT2: begin
            // overlapping the next accept with the last beat keeps 4 cycles/triangle
            if (last_q) begin
               state_d = ST_DONE;
            end else if (accept) begin
               tri_d   = tri_if.tri_in;
               last_d  = tri_if.tri_last;
               state_d = ST_CHECK;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      ready_d   = (state_d == ST_IDLE) | ((state_d == ST_EMIT2) & ~last_d);
      new_tri_d = (state_d == ST_EMIT0);
      done_d    = (state_d == ST_DONE);
      case (state_d)
         ST_EMIT0: vertex_d = rel[0];
         ST_EMIT1: vertex_d = rel1_q;
         ST_EMIT2: vertex_d = rel2_q;
         default:  vertex_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         tri_q     <= '0;
         last_q    <= 1'b0;
         cam_q     <= '0;
         rel1_q    <= '0;
         rel2_q    <= '0;
         vertex_q  <= '0;
         color_q   <= '0;
         new_tri_q <= 1'b0;
         done_q    <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         tri_q     <= tri_d;
         last_q    <= last_d;
         cam_q     <= cam_d;
         rel1_q    <= rel1_d;
         rel2_q    <= rel2_d;
         vertex_q  <= vertex_d;
         color_q   <= color_d;
         new_tri_q <= new_tri_d;
         done_q    <= done_d;
         ready_q   <= ready_d;
      end
   end

   assign vertex           = vertex_q;
   assign color            = color_q;
   assign new_triangle_out = new_tri_q;
   assign done_out         = done_q;
   assign tri_if.tri_ready = ready_q;

`ifdef DDD_CULL_STATS_EN
   logic [15:0] culled_q, culled_d;
   logic [15:0] emitted_q, emitted_d;

   always_comb begin
      culled_d  = culled_q;
      emitted_d = emitted_q;
      if (cam_load) begin
         culled_d  = '0;
         emitted_d = '0;
      end
      if ((state_q == ST_CHECK) && cull && (culled_q != 16'hFFFF))
         culled_d = culled_q + 16'd1;
      if ((state_q == ST_EMIT2) && (emitted_q != 16'hFFFF))
         emitted_d = emitted_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         culled_q  <= '0;
         emitted_q <= '0;
      end else begin
         culled_q  <= culled_d;
         emitted_q <= emitted_d;
      end
   end

   assign culled_count  = culled_q;
   assign emitted_count = emitted_q;
`endif

endmodule
